// File: rtl/lcd_interface_if.sv
// lcd_interface_if: CPU-side strobes/data and HD44780-style panel pins.
interface lcd_interface_if;
    logic [11:0] dbus;
    logic        lcd_wr;
    logic        lcd_rd;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;
    logic [11:0] status;
    modport master (output dbus, lcd_wr, lcd_rd, input lcd_e, lcd_rs, lcd_rw, lcd_data, status);
    modport slave  (input dbus, lcd_wr, lcd_rd, output lcd_e, lcd_rs, lcd_rw, lcd_data, status);
endinterface

// File: rtl/lcd_interface.sv
// lcd_interface: paced panel write sequencer with one-deep pending buffer and sticky overrun.
module lcd_interface #(
    parameter int SETUP_CYCLES   = 2,
    parameter int PULSE_CYCLES   = 12,
    parameter int HOLD_CYCLES    = 2,
    parameter int RECOVER_CYCLES = 100
) (
    input logic clk,
    input logic rst,
    lcd_interface_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOVER} state_t;
    state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0] data_q, data_n;
    logic [8:0] buf_q, buf_n;
    logic wr_q, rd_q, e_q, rs_q, rs_n, pend_q, pend_n, ovr_q, ovr_n, busy_q;
    logic wr_edge, rd_edge, done, last;
    function automatic logic [15:0] reload(input state_t s);
        return s == SETUP   ? 16'(SETUP_CYCLES - 1) :
               s == PULSE   ? 16'(PULSE_CYCLES - 1) :
               s == HOLD    ? 16'(HOLD_CYCLES - 1) :
               s == RECOVER ? 16'(RECOVER_CYCLES - 1) : 16'd0;
    endfunction
    assign wr_edge = bus.lcd_wr & ~wr_q;
    assign rd_edge = bus.lcd_rd & ~rd_q;
    assign done    = cnt == 16'd0;
    assign last    = state == RECOVER && done;
    always_comb begin
        state_n = state;
        cnt_n   = done ? cnt : cnt - 16'd1;
        data_n  = data_q;
        rs_n    = rs_q;
        buf_n   = buf_q;
        pend_n  = pend_q;
        ovr_n   = ovr_q & ~rd_edge;
        case (state)
            IDLE:    state_n = wr_edge ? SETUP : IDLE;
            SETUP:   state_n = done ? PULSE : SETUP;
            PULSE:   state_n = done ? HOLD : PULSE;
            HOLD:    state_n = done ? RECOVER : HOLD;
            RECOVER: state_n = done ? ((pend_q | wr_edge) ? SETUP : IDLE) : RECOVER;
            default: state_n = IDLE;
        endcase
        if (state == IDLE && wr_edge)
            {rs_n, data_n} = bus.dbus[8:0];
        else if (wr_edge) begin
            if (last && !pend_q)
                {rs_n, data_n} = bus.dbus[8:0];
            else if (last || !pend_q) begin
                buf_n  = bus.dbus[8:0];
                pend_n = 1'b1;
            end else
                ovr_n = 1'b1;
        end
        if (last && pend_q) begin
            {rs_n, data_n} = buf_q;
            pend_n = wr_edge;
        end
        if (state_n != state)
            cnt_n = reload(state_n);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            buf_q  <= 9'd0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            rs_q   <= rs_n;
            e_q    <= state_n == PULSE;
            buf_q  <= buf_n;
            pend_q <= pend_n;
            ovr_q  <= ovr_n;
            busy_q <= state_n != IDLE;
            wr_q   <= bus.lcd_wr;
            rd_q   <= bus.lcd_rd;
        end
    end
    assign bus.lcd_e    = e_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = data_q;
    assign bus.status   = {9'b0, ovr_q, pend_q, busy_q};
endmodule

// File: tb/tb_lcd_interface.sv
// tb_lcd_interface: directed timing checks of lcd_interface with SETUP=2 PULSE=4 HOLD=2 RECOVER=8.
module tb_lcd_interface;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_bad = 0;
    int rises;
    logic e_prev;
    lcd_interface_if bus();
    lcd_interface #(.SETUP_CYCLES(2), .PULSE_CYCLES(4), .HOLD_CYCLES(2), .RECOVER_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic do_reset(input logic wr_hold);
        rst = 1'b1;
        bus.lcd_wr = wr_hold;
        bus.lcd_rd = 1'b0;
        bus.dbus = 12'h000;
        tick();
        tick();
        rst = 1'b0;
        check("reset_status", 32'(bus.status), 32'h000);
        check("reset_e", 32'(bus.lcd_e), 32'h0);
        check("reset_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h000);
        check("reset_rw", 32'(bus.lcd_rw), 32'h0);
    endtask
    initial begin
        do_reset(1'b0);
        rises = 0;
        e_prev = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            bus.lcd_wr = c < 5;
            bus.dbus = 12'h141;
            if (c >= 1) check("t1_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h141);
            check("t1_e", 32'(bus.lcd_e), 32'(c >= 3 && c <= 6));
            check("t1_busy", 32'(bus.status[0]), 32'(c >= 1 && c <= 16));
            if (bus.lcd_e && !e_prev) rises++;
            e_prev = bus.lcd_e;
            tick();
        end
        check("t1_transfers", 32'(rises), 32'd1);
        do_reset(1'b0);
        for (int c = 0; c <= 36; c++) begin
            bus.lcd_wr = c == 0 || c == 5;
            bus.dbus = c < 5 ? 12'h030 : 12'h00C;
            check("t2_pending", 32'(bus.status[1]), 32'(c >= 6 && c <= 16));
            check("t2_busy", 32'(bus.status[0]), 32'(c >= 1 && c <= 32));
            check("t2_e", 32'(bus.lcd_e), 32'((c >= 3 && c <= 6) || (c >= 19 && c <= 22)));
            if (c >= 1) check("t2_data", 32'({bus.lcd_rs, bus.lcd_data}), c >= 17 ? 32'h00C : 32'h030);
            tick();
        end
        do_reset(1'b0);
        for (int c = 0; c <= 34; c++) begin
            bus.lcd_wr = c == 0 || c == 3 || c == 6;
            bus.lcd_rd = c == 10;
            bus.dbus = c == 0 ? 12'h101 : c == 3 ? 12'h102 : 12'h103;
            if (c >= 7 && c <= 16) check("t3_status", 32'(bus.status), c <= 10 ? 32'h007 : 32'h003);
            if (c >= 17 && c <= 32) check("t3_second", 32'({bus.lcd_rs, bus.lcd_data}), 32'h102);
            if (c >= 33) check("t3_idle", 32'(bus.status), 32'h000);
            tick();
        end
        do_reset(1'b0);
        rises = 0;
        e_prev = 1'b0;
        for (int c = 0; c <= 52; c++) begin
            bus.lcd_wr = c == 0 || c == 2 || c == 16;
            bus.dbus = c == 0 ? 12'h011 : c == 2 ? 12'h022 : 12'h133;
            check("t4_overrun", 32'(bus.status[2]), 32'h0);
            check("t4_busy", 32'(bus.status[0]), 32'(c >= 1 && c <= 48));
            if (c == 5) check("t4_first", 32'({bus.lcd_rs, bus.lcd_data}), 32'h011);
            if (c == 20) check("t4_second", 32'({bus.lcd_rs, bus.lcd_data}), 32'h022);
            if (c == 36) check("t4_third", 32'({bus.lcd_rs, bus.lcd_data}), 32'h133);
            if (c == 17) check("t4_pend_keep", 32'(bus.status[1]), 32'h1);
            if (c == 33) check("t4_pend_clr", 32'(bus.status[1]), 32'h0);
            if (bus.lcd_e && !e_prev) rises++;
            e_prev = bus.lcd_e;
            tick();
        end
        check("t4_transfers", 32'(rises), 32'd3);
        do_reset(1'b0);
        for (int c = 0; c <= 24; c++) begin
            bus.lcd_wr = c == 0 || c == 6;
            bus.dbus = c == 0 ? 12'h141 : 12'h155;
            rst = c == 4;
            if (c == 4) check("t5_e_mid", 32'(bus.lcd_e), 32'h1);
            if (c == 5) begin
                check("t5_e", 32'(bus.lcd_e), 32'h0);
                check("t5_status", 32'(bus.status), 32'h000);
                check("t5_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h000);
            end
            if (c >= 7) begin
                check("t5_data2", 32'({bus.lcd_rs, bus.lcd_data}), 32'h155);
                check("t5_e2", 32'(bus.lcd_e), 32'(c >= 9 && c <= 12));
                check("t5_busy2", 32'(bus.status[0]), 32'(c <= 22));
            end
            tick();
        end
        do_reset(1'b1);
        bus.dbus = 12'h07F;
        tick();
        check("t6_held_wr", 32'(bus.status[0]), 32'h1);
        check("t6_data", 32'({bus.lcd_rs, bus.lcd_data}), 32'h07F);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_interface.md
LCD_INTERFACE -- requirements
Module: lcd_interface

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles lcd_rs/lcd_data are stable before lcd_e rises (range 1..255).
REQ-002 SHALL have parameter PULSE_CYCLES, default 12: cycles lcd_e is high (range 1..255).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2: cycles lcd_rs/lcd_data stay stable after lcd_e falls (range 1..255).
REQ-004 SHALL have parameter RECOVER_CYCLES, default 100: idle gap before the next transfer, covering the panel execution time (range 1..65535).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 dbus  input  12  data bus; [7:0] = LCD byte, [8] = RS, [11:9] ignored.
REQ-008 lcd_wr  input  1  write strobe from the address decoder; level, any length.
REQ-009 lcd_rd  input  1  status-read strobe; level, any length.
REQ-010 lcd_e  output  1  panel enable.
REQ-011 lcd_rs  output  1  panel register select.
REQ-012 lcd_rw  output  1  panel read/write; SHALL be constant 0.
REQ-013 lcd_data  output  8  panel data bus.
REQ-014 status  output  12  {9'b0, overrun, pending, busy}.

Function
REQ-015 A write SHALL be accepted only on a rising edge of lcd_wr: lcd_wr=1 this cycle and 0 the previous cycle, using a registered copy. A held strobe SHALL produce exactly one write.
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, RECOVER.
REQ-017 Each non-IDLE state SHALL last exactly its parameter's count of cycles. Order: SETUP->PULSE->HOLD->RECOVER.
REQ-018 A write accepted in IDLE SHALL load lcd_data=dbus[7:0] and lcd_rs=dbus[8] at that clock edge and enter SETUP.
REQ-019 lcd_e SHALL be 1 only in PULSE. It SHALL be registered and glitch-free.
REQ-020 lcd_data/lcd_rs SHALL change only when entering SETUP.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Pending buffer: one entry (9 bits).
  - A write accepted while busy=1 SHALL be stored if the buffer is empty, and pending SHALL be set.
REQ-023 On leaving RECOVER:
  - pending=1: load the buffer into lcd_data/lcd_rs, clear pending, go directly to SETUP (no IDLE cycle).
  - pending=0: go to IDLE.
REQ-024 A write accepted in the same cycle the buffer drains (last RECOVER cycle) SHALL be stored into the buffer, pending stays 1, no overrun.
REQ-025 A write accepted while busy=1 and pending=1 (outside REQ-024) SHALL be discarded and overrun SHALL be set.
REQ-026 overrun SHALL be sticky. It SHALL clear on the cycle after a rising edge of lcd_rd.
  - status SHALL still show overrun=1 during the cycle that edge is detected.
  - If a new overrun and an lcd_rd edge coincide, overrun SHALL remain 1.
REQ-027 status SHALL be a registered view of the busy/pending/overrun flags, valid every cycle regardless of lcd_rd.
REQ-028 Phase counter SHALL be 16 bits and SHALL be reloaded on every state entry. There is no wrap-around path.

Reset
REQ-029 When rst=1 at a clock edge, the following values SHALL take effect that edge, regardless of state, including mid-PULSE:
  - state=IDLE
  - lcd_e=0, lcd_rs=0, lcd_data=8'h00, lcd_rw=0
  - pending=0, overrun=0, busy=0, status=12'h000
  - buffer=0
  - lcd_wr/lcd_rd edge registers=0
REQ-030 A lcd_wr held high through reset release SHALL count as a rising edge on the first cycle after reset.

Verification (SETUP=2, PULSE=4, HOLD=2, RECOVER=8)
REQ-031 Single write, dbus=12'h141, lcd_wr rises at cycle 0 and is held 5 cycles:
  - lcd_data=8'h41, lcd_rs=1 from cycle 1.
  - lcd_e=1 cycles 3-6 only.
  - busy=1 cycles 1-16, IDLE at cycle 17.
  - exactly one transfer.
REQ-032 Back-to-back: writes 12'h030 (cycle 0) then 12'h00C (cycle 5, busy):
  - pending=1 from cycle 6.
  - second SETUP begins cycle 17, lcd_data=8'h0C, lcd_rs=0, lcd_e=1 cycles 19-22.
  - busy never drops between transfers.
REQ-033 Overrun: three write edges at cycles 0, 3, 6:
  - third write discarded, status=12'h007 from cycle 7.
  - lcd_rd edge at cycle 10: status bit2=1 at cycle 10, 0 from cycle 11.
REQ-034 Drain collision: second write at cycle 2, third write edge at cycle 16 (last RECOVER):
  - overrun stays 0.
  - three transfers complete in order.
REQ-035 Reset mid-pulse: rst=1 at cycle 4 (lcd_e=1):
  - lcd_e=0, status=12'h000, lcd_data=8'h00 at cycle 5.
  - a new write after reset completes with normal timing.
